// File: rtl/sample_io_bridge_if.sv
// Signal bundle between the codec front end, pipeline_seq and sample_io_bridge.
// The bridge takes the master modport; the codec/pipeline side takes slave.
interface sample_io_bridge_if #(
   parameter int unsigned data_width = 16
);
   logic                  enable;
   logic [data_width-1:0] adc_sample;
   logic                  adc_valid;
   logic [data_width-1:0] pipe_in_sample;
   logic                  pipe_in_valid;
   logic [data_width-1:0] pipe_out_sample;
   logic                  pipe_ready;
   logic                  pipe_error;
   logic [data_width-1:0] dac_sample;
   logic                  dac_valid;
   logic [15:0]           overrun_count;
   logic                  timeout_flag;
   logic                  busy;

   modport master (
      input  enable,
      input  adc_sample,
      input  adc_valid,
      input  pipe_out_sample,
      input  pipe_ready,
      input  pipe_error,
      output pipe_in_sample,
      output pipe_in_valid,
      output dac_sample,
      output dac_valid,
      output overrun_count,
      output timeout_flag,
      output busy
   );

   modport slave (
      output enable,
      output adc_sample,
      output adc_valid,
      output pipe_out_sample,
      output pipe_ready,
      output pipe_error,
      input  pipe_in_sample,
      input  pipe_in_valid,
      input  dac_sample,
      input  dac_valid,
      input  overrun_count,
      input  timeout_flag,
      input  busy
   );
endinterface

// File: rtl/sample_io_bridge.sv
// Buffers one ADC sample per frame, hands it to pipeline_seq and returns the processed
// sample to the DAC; bypasses or replays the last good sample on disable, error or timeout.
module sample_io_bridge #(
   parameter int unsigned data_width     = 16,
   parameter int unsigned timeout_cycles = 4096,
   parameter int unsigned busy_window    = 4
) (
   input logic                clk,
   input logic                reset,
   sample_io_bridge_if.master bus
);
   localparam int unsigned cnt_width   = $clog2(timeout_cycles + 1);
   localparam int unsigned count_width = 16;

   typedef logic [data_width-1:0] sample_t;
   typedef logic [cnt_width-1:0]  cnt_t;
   typedef enum logic [2:0] {
      idle,
      issue,
      wait_busy,
      wait_done,
      capture,
      abort
   } state_t;

   state_t                 state;
   sample_t                held;
   sample_t                last_good;
   sample_t                pipe_in_sample;
   sample_t                dac_sample;
   logic                   pending;
   logic                   pipe_in_valid;
   logic                   dac_valid;
   logic                   timeout_flag;
   logic                   busy;
   logic [count_width-1:0] overrun_count;
   cnt_t                   total_cnt;

   logic go_issue_c;
   logic go_bypass_c;
   logic go_done_c;
   logic go_capture_c;
   logic go_abort_c;
   logic timed_out_c;
   logic pend_clear_c;

   // Transition decisions; total_cnt equals the number of cycles since ISSUE
   always_comb begin
      go_issue_c   = 1'b0;
      go_bypass_c  = 1'b0;
      go_done_c    = 1'b0;
      go_capture_c = 1'b0;
      go_abort_c   = 1'b0;
      timed_out_c  = (total_cnt >= cnt_t'(timeout_cycles - 1));
      case (state)
         idle: begin
            if (pending) begin
               if (!bus.enable || bus.pipe_error) begin
                  go_bypass_c = 1'b1;
               end else if (bus.pipe_ready) begin
                  go_issue_c = 1'b1;
               end
            end
         end
         wait_busy: begin
            // ready is only trusted from the second WAIT_BUSY cycle on
            if ((total_cnt > cnt_t'(1)) && !bus.pipe_ready) begin
               go_done_c = 1'b1;
            end else if ((total_cnt >= cnt_t'(busy_window)) || timed_out_c) begin
               go_abort_c = 1'b1;
            end
         end
         wait_done: begin
            if (bus.pipe_ready) begin
               go_capture_c = 1'b1;
            end else if (bus.pipe_error || timed_out_c) begin
               go_abort_c = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   assign pend_clear_c = (state == issue) || go_bypass_c;

   // Holding register; a strobe landing on the clearing cycle refills it without an overrun
   always_ff @(posedge clk) begin
      if (reset) begin
         held          <= '0;
         pending       <= 1'b0;
         overrun_count <= '0;
      end else if (bus.adc_valid) begin
         held    <= bus.adc_sample;
         pending <= 1'b1;
         if (pending && !pend_clear_c && (overrun_count != '1)) begin
            overrun_count <= overrun_count + count_width'(1);
         end
      end else if (pend_clear_c) begin
         pending <= 1'b0;
      end
   end

   // Sequencer; outputs for a state are registered on the edge that enters it
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= idle;
         pipe_in_sample <= '0;
         pipe_in_valid  <= 1'b0;
         dac_sample     <= '0;
         dac_valid      <= 1'b0;
         last_good      <= '0;
         timeout_flag   <= 1'b0;
         busy           <= 1'b0;
         total_cnt      <= '0;
      end else begin
         pipe_in_valid <= 1'b0;
         dac_valid     <= 1'b0;
         case (state)
            idle: begin
               if (go_issue_c) begin
                  state          <= issue;
                  pipe_in_sample <= held;
                  pipe_in_valid  <= 1'b1;
                  busy           <= 1'b1;
               end else if (go_bypass_c) begin
                  dac_sample <= held;
                  dac_valid  <= 1'b1;
               end
            end
            issue: begin
               state     <= wait_busy;
               total_cnt <= cnt_t'(1);
            end
            wait_busy, wait_done: begin
               if (total_cnt != '1) begin
                  total_cnt <= total_cnt + cnt_t'(1);
               end
               if (go_done_c) begin
                  state <= wait_done;
               end else if (go_capture_c) begin
                  state      <= capture;
                  dac_sample <= bus.pipe_out_sample;
                  last_good  <= bus.pipe_out_sample;
                  dac_valid  <= 1'b1;
               end else if (go_abort_c) begin
                  state        <= abort;
                  dac_sample   <= last_good;
                  dac_valid    <= 1'b1;
                  timeout_flag <= 1'b1;
               end
            end
            capture, abort: begin
               state <= idle;
               busy  <= 1'b0;
            end
            default: begin
               state <= idle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pipe_in_sample = pipe_in_sample;
   assign bus.pipe_in_valid  = pipe_in_valid;
   assign bus.dac_sample     = dac_sample;
   assign bus.dac_valid      = dac_valid;
   assign bus.overrun_count  = overrun_count;
   assign bus.timeout_flag   = timeout_flag;
   assign bus.busy           = busy;
endmodule
